apple_matrix_scan: RTL and testbench



---
 rtl/apple_matrix_scan.sv | 130 +++++++++++++
 tb/tb_apple_matrix_scan.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/apple_matrix_scan.sv
// 16x16 LED matrix scanner for the apple position, with per-row blanking and per-frame coordinate latching.
// Optional blink is built only when APPLE_MATRIX_SCAN_BLINK_EN is defined.
module apple_matrix_scan #(
   parameter int ROW_TICKS    = 1000,
   parameter int BLANK_TICKS  = 50,
   parameter int BLINK_FRAMES = 25
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [3:0]  apple_x,
   input  logic [3:0]  apple_y,
   output logic [15:0] row_sel,
   output logic [15:0] col_data,
   output logic        frame_start
);

   localparam int TW = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1;

   if (ROW_TICKS < 2) begin : g_bad_row_ticks
      $error("ROW_TICKS must be at least 2");
   end
   if (BLANK_TICKS < 0 || BLANK_TICKS >= ROW_TICKS) begin : g_bad_blank_ticks
      $error("BLANK_TICKS must be in 0..ROW_TICKS-1");
   end
   if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
      $error("BLINK_FRAMES must be at least 1");
   end

   // IDLE means the counters carry no position; the next enabled edge starts a fresh frame.
   typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_DRIVE} state_t;

   state_t         state, state_nxt;
   logic [TW-1:0]  tick, tick_nxt;
   logic [3:0]     row, row_nxt;
   logic [3:0]     shadow_x, shadow_y, sx_nxt, sy_nxt;
   logic           start_nxt;
   logic           wrap_frame;
   logic           lit_nxt;

   always_comb begin
      tick_nxt   = '0;
      row_nxt    = '0;
      start_nxt  = 1'b0;
      wrap_frame = 1'b0;
      if (enable) begin
         if (state == ST_IDLE) begin
            start_nxt = 1'b1;
         end else if (tick == TW'(ROW_TICKS - 1)) begin
            row_nxt = row + 4'd1;
            if (row == 4'd15) begin
               start_nxt  = 1'b1;
               wrap_frame = 1'b1;
            end
         end else begin
            tick_nxt = tick + 1'b1;
            row_nxt  = row;
         end
      end
      sx_nxt = start_nxt ? apple_x : shadow_x;
      sy_nxt = start_nxt ? apple_y : shadow_y;
      if (!enable)
         state_nxt = ST_IDLE;
      else if (int'(tick_nxt) < BLANK_TICKS)
         state_nxt = ST_BLANK;
      else
         state_nxt = ST_DRIVE;
   end

`ifdef APPLE_MATRIX_SCAN_BLINK_EN
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [BW-1:0] blink_cnt, blink_cnt_nxt;
   logic          blink_on, blink_on_nxt;

   // Only a natural 15->0 wrap advances the blink; a restart after enable keeps the phase.
   always_comb begin
      blink_cnt_nxt = blink_cnt;
      blink_on_nxt  = blink_on;
      if (wrap_frame) begin
         if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt_nxt = '0;
            blink_on_nxt  = ~blink_on;
         end else begin
            blink_cnt_nxt = blink_cnt + 1'b1;
         end
      end
      lit_nxt = blink_on_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else begin
         blink_cnt <= blink_cnt_nxt;
         blink_on  <= blink_on_nxt;
      end
   end
`else
   logic unused_wrap;
   assign unused_wrap = wrap_frame;
   assign lit_nxt     = 1'b1;
`endif

   // Outputs decode the next-state values so they line up with tick/row in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         tick        <= '0;
         row         <= '0;
         shadow_x    <= '0;
         shadow_y    <= '0;
         row_sel     <= '0;
         col_data    <= '0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nxt;
         tick        <= tick_nxt;
         row         <= row_nxt;
         shadow_x    <= sx_nxt;
         shadow_y    <= sy_nxt;
         frame_start <= start_nxt;
         row_sel     <= (state_nxt == ST_DRIVE) ? (16'd1 << row_nxt) : 16'd0;
         col_data    <= (state_nxt == ST_DRIVE && row_nxt == sy_nxt && lit_nxt)
                        ? (16'd1 << sx_nxt) : 16'd0;
      end
   end

endmodule

// File: tb/tb_apple_matrix_scan.sv
// Directed bench for apple_matrix_scan with ROW_TICKS=8, BLANK_TICKS=2, BLINK_FRAMES=2.
module tb_apple_matrix_scan;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [3:0]  apple_x = 4'd0;
   logic [3:0]  apple_y = 4'd0;
   logic [15:0] row_sel;
   logic [15:0] col_data;
   logic        frame_start;

   int vectors = 0;
   int errors  = 0;

   apple_matrix_scan #(.ROW_TICKS(8), .BLANK_TICKS(2), .BLINK_FRAMES(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .apple_x     (apple_x),
      .apple_y     (apple_y),
      .row_sel     (row_sel),
      .col_data    (col_data),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   // Expected {frame_start, row_sel, col_data} for cycle k (0..127) of a frame.
   function automatic logic [32:0] exp_vec(int k, logic [3:0] x, logic [3:0] y, logic lit);
      int r = k / 8;
      int t = k % 8;
      logic [15:0] rs = 16'd0;
      logic [15:0] cd = 16'd0;
      if (t >= 2) begin
         rs = 16'd1 << r;
         if (r == int'(y) && lit) cd = 16'd1 << x;
      end
      return {(k == 0), rs, cd};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at the first frame_start cycle after reset.
   task automatic do_reset(input logic [3:0] x, input logic [3:0] y);
      reset_n = 1'b0;
      enable  = 1'b1;
      apple_x = x;
      apple_y = y;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      enable  = 1'b1;
      apple_x = 4'd5;
      apple_y = 4'd3;
      for (int i = 0; i < 4; i++) begin
         step();
         vectors++;
         if ({frame_start, row_sel, col_data} !== 33'd0) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got %h want 0", i, {frame_start, row_sel, col_data});
         end
      end
      reset_n = 1'b1;
      step();
      vectors++;
      if ({frame_start, row_sel, col_data} !== exp_vec(0, 4'd5, 4'd3, 1'b1)) begin
         errors++;
         $display("FAIL first_frame_start got %h want %h",
                  {frame_start, row_sel, col_data}, exp_vec(0, 4'd5, 4'd3, 1'b1));
      end
   endtask

   task automatic test_scan();
      for (int k = 1; k < 128; k++) begin
         step();
         vectors++;
         if ({frame_start, row_sel, col_data} !== exp_vec(k, 4'd5, 4'd3, 1'b1)) begin
            errors++;
            $display("FAIL scan k=%0d got %h want %h", k,
                     {frame_start, row_sel, col_data}, exp_vec(k, 4'd5, 4'd3, 1'b1));
         end
      end
      step();
      vectors++;
      if ({frame_start, row_sel, col_data} !== exp_vec(0, 4'd5, 4'd3, 1'b1)) begin
         errors++;
         $display("FAIL frame_repeat got %h want %h",
                  {frame_start, row_sel, col_data}, exp_vec(0, 4'd5, 4'd3, 1'b1));
      end
   endtask

   task automatic test_tear_free();
      do_reset(4'd5, 4'd3);
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < 128; k++) begin
            if (k > 0 || f > 0) step();
            if (f == 0 && k == 60) apple_x = 4'd9;
            vectors++;
            if ({frame_start, row_sel, col_data} !==
                exp_vec(k, (f == 0) ? 4'd5 : 4'd9, 4'd3, 1'b1)) begin
               errors++;
               $display("FAIL tear_free f=%0d k=%0d got %h want %h", f, k,
                        {frame_start, row_sel, col_data},
                        exp_vec(k, (f == 0) ? 4'd5 : 4'd9, 4'd3, 1'b1));
            end
         end
      end
   endtask

   task automatic test_blink();
      logic lit;
      do_reset(4'd7, 4'd3);
      for (int f = 0; f < 6; f++) begin
`ifdef APPLE_MATRIX_SCAN_BLINK_EN
         lit = ((f / 2) % 2) == 0;
`else
         lit = 1'b1;
`endif
         for (int k = 0; k < 128; k++) begin
            if (k > 0 || f > 0) step();
            vectors++;
            if ({frame_start, row_sel, col_data} !== exp_vec(k, 4'd7, 4'd3, lit)) begin
               errors++;
               $display("FAIL blink f=%0d k=%0d got %h want %h", f, k,
                        {frame_start, row_sel, col_data}, exp_vec(k, 4'd7, 4'd3, lit));
            end
         end
      end
   endtask

   task automatic test_enable_drop();
      do_reset(4'd2, 4'd6);
      for (int k = 1; k <= 52; k++) step();
      vectors++;
      if ({frame_start, row_sel, col_data} !== exp_vec(52, 4'd2, 4'd6, 1'b1)) begin
         errors++;
         $display("FAIL pre_drop got %h want %h",
                  {frame_start, row_sel, col_data}, exp_vec(52, 4'd2, 4'd6, 1'b1));
      end
      enable  = 1'b0;
      apple_x = 4'd1;
      apple_y = 4'd0;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if ({frame_start, row_sel, col_data} !== 33'd0) begin
            errors++;
            $display("FAIL disabled cyc=%0d got %h want 0", i, {frame_start, row_sel, col_data});
         end
      end
      enable = 1'b1;
      for (int k = 0; k < 128; k++) begin
         step();
         vectors++;
         if ({frame_start, row_sel, col_data} !== exp_vec(k, 4'd1, 4'd0, 1'b1)) begin
            errors++;
            $display("FAIL reenable k=%0d got %h want %h", k,
                     {frame_start, row_sel, col_data}, exp_vec(k, 4'd1, 4'd0, 1'b1));
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset(4'd5, 4'd3);
      for (int k = 1; k <= 28; k++) step();
      vectors++;
      if ({frame_start, row_sel, col_data} !== exp_vec(28, 4'd5, 4'd3, 1'b1)) begin
         errors++;
         $display("FAIL pre_reset got %h want %h",
                  {frame_start, row_sel, col_data}, exp_vec(28, 4'd5, 4'd3, 1'b1));
      end
      #2;
      reset_n = 1'b0;
      apple_x = 4'd12;
      #1;
      vectors++;
      if ({frame_start, row_sel, col_data} !== 33'd0) begin
         errors++;
         $display("FAIL async_clear got %h want 0", {frame_start, row_sel, col_data});
      end
      step();
      reset_n = 1'b1;
      for (int k = 0; k < 128; k++) begin
         step();
         vectors++;
         if ({frame_start, row_sel, col_data} !== exp_vec(k, 4'd12, 4'd3, 1'b1)) begin
            errors++;
            $display("FAIL post_reset k=%0d got %h want %h", k,
                     {frame_start, row_sel, col_data}, exp_vec(k, 4'd12, 4'd3, 1'b1));
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_tear_free();
      test_blink();
      test_enable_drop();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
